// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg
// Shared encodings for the multicycle RV32I control path.
//   - state_t     : controller FSM states
//   - OP_*        : supported major opcodes (instr[6:0])
//   - ALU_*       : alu_control codes seen by the ALU
//   - ALUOP_*     : coarse ALU request from the FSM to alu_decoder
//   - SRCA_*, SRCB_*, RES_*, IMM_* : datapath mux select codes
// ---------------------------------------------------------------------------
package control_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH,
        JAL,
        ILLEGAL
    } state_t;

    // Major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Coarse ALU request from the FSM
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_RDATA     = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Immediate format select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational translation of the FSM's coarse ALU request into the ALU
// operation code.
//   alu_op      in  2 : 00 add, 01 sub, 10 decode from funct fields
//   funct3      in  3 : instr[14:12]
//   op_b5       in  1 : instr[5], distinguishes R-type from I-type
//   funct7b5    in  1 : instr[30]
//   alu_control out 3 : ALU operation code (see control_pkg ALU_*)
// ---------------------------------------------------------------------------
module alu_decoder
    import control_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        unique case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type with funct7b5 set is a subtract; addi has
                    // no subtract form so op_b5 qualifies it.
                    3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    // Every remaining funct3 encoding resolves to add and
                    // never raises the illegal flag.
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Main control FSM of the multicycle RV32I core. Sequences fetch, decode,
// execute, memory and writeback, and drives every datapath enable and mux.
//   clk         in  1 : clock, rising edge
//   reset       in  1 : asynchronous reset, active low (0 = in reset)
//   op          in  7 : instr[6:0]
//   funct3      in  3 : instr[14:12]
//   funct7b5    in  1 : instr[30]
//   zero        in  1 : ALU zero flag of the current cycle
//   mem_ready   in  1 : memory completes the current access this cycle
//   pc_write    out 1 : PC flop enable
//   ir_write    out 1 : IR / old-PC flop enable
//   reg_write   out 1 : register file write enable
//   mem_write   out 1 : memory write strobe
//   adr_src     out 1 : memory address select (0 PC, 1 ALUOut)
//   alu_src_a   out 2 : ALU operand A select
//   alu_src_b   out 2 : ALU operand B select
//   result_src  out 2 : result bus select
//   imm_src     out 2 : immediate format select
//   alu_control out 3 : ALU operation
//   illegal     out 1 : sticky unsupported-opcode flag
// ---------------------------------------------------------------------------
module multicycle_controller
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal
);

    state_t     state_q;
    state_t     state_d;

    logic       pc_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       mem_write_c;
    logic [1:0] alu_op_c;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_d = MEMADR;
                    OP_RTYPE:  state_d = EXECUTER;
                    OP_ITYPE:  state_d = EXECUTEI;
                    OP_BRANCH: state_d = BRANCH;
                    OP_JAL:    state_d = JAL;
                    default:   state_d = ILLEGAL;
                endcase
            end
            // Only lw and sw reach MEMADR, so comparing against the store
            // opcode is enough to pick the direction.
            MEMADR:   state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD: begin
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB:    state_d = FETCH;
            MEMWRITE: begin
                if (mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JAL:      state_d = FETCH;
            // Terminal until reset.
            ILLEGAL:  state_d = ILLEGAL;
            default:  state_d = FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. Everything is a function of state except the fetch
    // handshake (mem_ready) and the branch decision (zero).
    // ------------------------------------------------------------------
    always_comb begin
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        result_src  = RES_ALUOUT;
        imm_src     = IMM_I;
        alu_op_c    = ALUOP_ADD;
        illegal     = 1'b0;
        unique case (state_q)
            FETCH: begin
                // PC + 4 goes straight from the ALU result into the PC in
                // the same cycle the instruction word is captured.
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
            end
            DECODE: begin
                // Precompute old-PC + B-immediate into ALUOut so a taken
                // branch can load it in the BRANCH state.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            MEMREAD: begin
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src  = RES_RDATA;
                reg_write_c = 1'b1;
            end
            MEMWRITE: begin
                // Strobe stays up for the whole access; the slave samples
                // it on the cycle it raises mem_ready.
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op_c  = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                alu_op_c  = ALUOP_FUNCT;
            end
            ALUWB: begin
                result_src  = RES_ALUOUT;
                reg_write_c = 1'b1;
            end
            BRANCH: begin
                // beq (funct3[0]=0) takes the branch on zero, bne on not zero.
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op_c   = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write_c = zero ^ funct3[0];
            end
            JAL: begin
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_FOUR;
                result_src  = RES_ALUOUT;
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
            end
            ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op_c),
        .funct3      (funct3),
        .op_b5       (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

    // The state register already sits in FETCH during reset, but FETCH's
    // enables follow mem_ready combinationally, so they must also be masked
    // by reset itself to keep every write suppressed while it is held.
    assign pc_write  = pc_write_c  & reset;
    assign ir_write  = ir_write_c  & reset;
    assign reg_write = reg_write_c & reset;
    assign mem_write = mem_write_c & reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
// Self-checking bench for multicycle_controller. Each instruction is expanded
// into its expected per-cycle control word from the instruction class,
// funct fields and memory wait counts, then compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int K_R   = 0;
    localparam int K_I   = 1;
    localparam int K_LW  = 2;
    localparam int K_SW  = 3;
    localparam int K_BR  = 4;
    localparam int K_JAL = 5;
    localparam int K_BAD = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal;

    int errors = 0;
    int checks = 0;

    logic [16:0] obs_vec;
    assign obs_vec = {pc_write, ir_write, reg_write, mem_write, adr_src,
                      alu_src_a, alu_src_b, result_src, imm_src,
                      alu_control, illegal};

    multicycle_controller dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .adr_src     (adr_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Packs an expected control word in the same field order as obs_vec.
    function automatic logic [16:0] mk(input logic pcw, input logic irw,
                                       input logic rgw, input logic mw,
                                       input logic adr, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] res,
                                       input logic [1:0] imm, input logic [2:0] alu,
                                       input logic ill);
        return {pcw, irw, rgw, mw, adr, a, b, res, imm, alu, ill};
    endfunction

    // ALU operation an instruction asks for, from its funct fields.
    function automatic logic [2:0] refAlu(input logic [2:0] f3, input logic isR,
                                          input logic f7);
        case (f3)
            3'b000:  return (isR && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b100:  return 3'b100;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Control word while in reset: fetch mux settings, no enables.
    function automatic logic [16:0] resetVec();
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0);
    endfunction

    function automatic logic [16:0] fetchVec(input logic r);
        return mk(r, r, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [16:0] expected);
        checks++;
        assert (obs_vec === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs_vec, expected);
        end
    endtask

    // One cycle: drive inputs on the falling edge, check just after.
    task automatic applyStimulus(input logic mr, input logic z,
                                 input logic [16:0] expected, input string tag);
        @(negedge clk);
        mem_ready = mr;
        zero      = z;
        #1;
        checkOutput(tag, expected);
    endtask

    // Asserts reset in the middle of a cycle, checks the asynchronous effect,
    // holds it, then releases with no memory ready.
    task automatic resetMidCycle(input string tag);
        @(negedge clk);
        #2;
        mem_ready = 1'b1;
        reset     = 1'b0;
        #1;
        checkOutput(tag, resetVec());
        applyStimulus(1'b1, rbit(), resetVec(), "reset_hold");
        applyStimulus(1'b1, rbit(), resetVec(), "reset_hold");
        @(negedge clk);
        mem_ready = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic runInstr(input int kind, input logic [2:0] f3, input logic f7,
                            input logic z, input int fw, input int mw,
                            input logic [6:0] badOp, input bit skipFetch);
        logic r;
        case (kind)
            K_R:     op = 7'b0110011;
            K_I:     op = 7'b0010011;
            K_LW:    op = 7'b0000011;
            K_SW:    op = 7'b0100011;
            K_BR:    op = 7'b1100011;
            K_JAL:   op = 7'b1101111;
            default: op = badOp;
        endcase
        funct3   = f3;
        funct7b5 = f7;
        if (!skipFetch) begin
            for (int i = 0; i <= fw; i++) begin
                r = (i == fw);
                applyStimulus(r, rbit(), fetchVec(r), "fetch");
            end
        end
        applyStimulus(rbit(), rbit(),
                      mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000, 0), "decode");
        case (kind)
            K_R: begin
                applyStimulus(rbit(), rbit(),
                              mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00,
                                 refAlu(f3, 1'b1, f7), 0), "exec_r");
                applyStimulus(rbit(), rbit(),
                              mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "aluwb");
            end
            K_I: begin
                applyStimulus(rbit(), rbit(),
                              mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00,
                                 refAlu(f3, 1'b0, f7), 0), "exec_i");
                applyStimulus(rbit(), rbit(),
                              mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "aluwb");
            end
            K_LW: begin
                applyStimulus(rbit(), rbit(),
                              mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 0), "memadr_lw");
                for (int i = 0; i <= mw; i++) begin
                    r = (i == mw);
                    applyStimulus(r, rbit(),
                                  mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "memread");
                end
                applyStimulus(rbit(), rbit(),
                              mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 0), "memwb");
            end
            K_SW: begin
                applyStimulus(rbit(), rbit(),
                              mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000, 0), "memadr_sw");
                for (int i = 0; i <= mw; i++) begin
                    r = (i == mw);
                    applyStimulus(r, rbit(),
                                  mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "memwrite");
                end
            end
            K_BR: begin
                // beq branches when equal (zero), bne when not equal.
                applyStimulus(rbit(), z,
                              mk(f3[0] ? ~z : z, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00,
                                 3'b001, 0), "branch");
            end
            K_JAL: begin
                applyStimulus(rbit(), rbit(),
                              mk(1, 0, 1, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 0), "jal");
            end
            default: begin
                for (int i = 0; i < 10; i++) begin
                    applyStimulus(rbit(), rbit(),
                                  mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1),
                                  "illegal_hold");
                end
                resetMidCycle("illegal_cleared");
            end
        endcase
    endtask

    initial begin
        int kind;
        logic [2:0] f3;

        $display("[TB] multicycle_controller bench starting");

        // Reset held for three cycles with memory ready.
        #1 reset = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, rbit(), resetVec(), "reset_hold");
        end

        // Release: the first edge with mem_ready high completes a fetch.
        op       = 7'b0110011;
        funct3   = 3'b000;
        funct7b5 = 1'b1;
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        checkOutput("first_fetch", fetchVec(1'b1));
        runInstr(K_R, 3'b000, 1'b1, 1'b0, 0, 0, 7'h00, 1'b1);

        // Directed cases.
        runInstr(K_LW, 3'b010, 1'b0, 1'b0, 0, 2, 7'h00, 1'b0);
        runInstr(K_BR, 3'b001, 1'b0, 1'b0, 0, 0, 7'h00, 1'b0);
        runInstr(K_BR, 3'b001, 1'b0, 1'b1, 0, 0, 7'h00, 1'b0);
        runInstr(K_BR, 3'b000, 1'b0, 1'b1, 1, 0, 7'h00, 1'b0);
        runInstr(K_BR, 3'b000, 1'b0, 1'b0, 0, 0, 7'h00, 1'b0);
        runInstr(K_SW, 3'b010, 1'b0, 1'b0, 0, 3, 7'h00, 1'b0);
        runInstr(K_I,  3'b000, 1'b1, 1'b0, 2, 0, 7'h00, 1'b0);
        runInstr(K_R,  3'b001, 1'b1, 1'b0, 0, 0, 7'h00, 1'b0);
        runInstr(K_JAL, 3'b000, 1'b0, 1'b0, 0, 0, 7'h00, 1'b0);
        runInstr(K_BAD, 3'b000, 1'b0, 1'b0, 0, 0, 7'b1111111, 1'b0);

        // Reset in the middle of a stalled store must kill the write strobe.
        op     = 7'b0100011;
        funct3 = 3'b010;
        applyStimulus(1'b1, rbit(), fetchVec(1'b1), "fetch");
        applyStimulus(rbit(), rbit(),
                      mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000, 0), "decode");
        applyStimulus(rbit(), rbit(),
                      mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000, 0), "memadr_sw");
        applyStimulus(1'b0, rbit(),
                      mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "memwrite");
        applyStimulus(1'b0, rbit(),
                      mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "memwrite");
        resetMidCycle("reset_midwrite");

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 5));
            f3   = 3'($urandom_range(0, 7));
            if (kind == K_BR) begin
                f3 = {2'b00, f3[0]};
            end
            runInstr(kind, f3, rbit(), rbit(), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 2)), 7'h00, 1'b0);
        end

        // An unsupported but real opcode (lui) must also trap.
        runInstr(K_BAD, 3'b000, 1'b0, 1'b0, 1, 0, 7'b0110111, 1'b0);
        runInstr(K_I, 3'b111, 1'b0, 1'b0, 0, 0, 7'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I core. It decodes the instruction register fields and sequences the core's enable flops: PC, IR/old-PC, register file, and memory write. It also drives every datapath mux select and the ALU operation. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

## Interface
- No parameters; all encodings are fixed in the shared package.
- `clk` in 1 — single clock; all state updates on rising edge.
- `reset` in 1 — asynchronous, active-low reset; 0 = in reset.
- `op` in 7 — instr[6:0].
- `funct3` in 3 — instr[14:12].
- `funct7b5` in 1 — instr[30].
- `zero` in 1 — ALU zero flag, combinational from the current-cycle ALU result.
- `mem_ready` in 1 — memory completes the current access this cycle.
- `pc_write` out 1 — enable for PC flop.
- `ir_write` out 1 — enable for IR and old-PC flops.
- `reg_write` out 1 — register file write enable.
- `mem_write` out 1 — memory write strobe.
- `adr_src` out 1 — memory address: 0 = PC, 1 = ALUOut.
- `alu_src_a` out 2 — 00 PC, 01 old-PC, 10 rs1 data.
- `alu_src_b` out 2 — 00 rs2 data, 01 immediate, 10 constant 4.
- `result_src` out 2 — 00 ALUOut, 01 read data, 10 ALU result.
- `imm_src` out 2 — 00 I, 01 S, 10 B, 11 J.
- `alu_control` out 3 — 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- `illegal` out 1 — sticky illegal-opcode flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, ILLEGAL.
- FETCH
  - Drives adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - While mem_ready=0: hold in FETCH with all enables 0.
  - On mem_ready=1: assert ir_write=1 and pc_write=1, then go to DECODE.
- DECODE
  - Drives alu_src_a=01, alu_src_b=01, imm_src=10, add, which precomputes the branch target.
  - Next state by op:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - Anything else → ILLEGAL.
- MEMADR
  - Drives rs1 + imm, add; imm_src is I for lw, S for sw.
  - Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD
  - Drives adr_src=1.
  - Waits for mem_ready, then goes to MEMWB.
- MEMWB
  - Drives result_src=01, reg_write=1; returns to FETCH.
- MEMWRITE
  - Holds adr_src=1 and mem_write=1 until mem_ready=1, then goes to FETCH.
- EXECUTER
  - Drives alu_src_a=10, alu_src_b=00, funct-decoded operation.
  - Next state: ALUWB.
- EXECUTEI
  - Drives alu_src_a=10, alu_src_b=01, imm_src=00, funct-decoded operation.
  - Next state: ALUWB.
- ALUWB
  - Drives result_src=00, reg_write=1; returns to FETCH.
- BRANCH
  - Drives alu_src_a=10, alu_src_b=00, sub, result_src=00.
  - pc_write = zero XNOR (funct3[0]=0); supports beq (funct3 000) and bne (funct3 001).
  - Next state: FETCH.
- JAL
  - Drives alu_src_a=01, alu_src_b=10, add, result_src=00, reg_write=1, pc_write=1.
  - Next state: FETCH.
- ILLEGAL
  - Terminal state: illegal=1, all enables 0; exits only via reset.
- ALU decode (funct-decoded states)
  - funct3 000: sub only when op[5]=1 and funct7b5=1, otherwise add.
  - funct3 010 → slt; 100 → xor; 110 → or; 111 → and.
  - Any other funct3 → add. This does not trigger ILLEGAL.
- Outputs not listed for a state are 0.

## Timing
- State register is asynchronous: on reset=0 it goes to FETCH immediately.
  - All enables (pc_write, ir_write, reg_write, mem_write) are forced 0 while reset=0.
  - illegal clears to 0; mux selects take their FETCH values.
- Reset release: the first possible fetch completes on the first edge at which mem_ready=1.
- Outputs are Moore, except:
  - pc_write in BRANCH (depends on zero).
  - ir_write/pc_write in FETCH and mem_write-completion transitions (depend on mem_ready).
- Cycles per instruction with zero-wait memory (mem_ready tied high):
  - R/I-ALU: 4. lw: 5. sw: 4. beq/bne: 3. jal: 3.
- Each memory-wait cycle adds 1 cycle.
- Reset asserted mid-instruction: the write for the in-flight state is suppressed in that cycle, and execution restarts in FETCH.

## Structure
- Package `control_pkg`:
  - state enum.
  - opcode localparams.
  - alu_control codes.
  - mux-select codes for alu_src_a/b, result_src, imm_src.
- Sub-module `alu_decoder`: combinational; inputs alu_op (2 bits: 00 add, 01 sub, 10 funct), funct3, op[5], funct7b5; output alu_control.
- The FSM instantiates `alu_decoder`.

## Test plan
- Reset with reset=0 for 3 cycles while mem_ready=1 → all enables 0, illegal=0. After release, first edge: ir_write=1, pc_write=1.
- op=0110011, funct3=000, funct7b5=1, mem_ready=1 → state sequence FETCH→DECODE→EXECUTER→ALUWB; alu_control=001 in EXECUTER; reg_write=1 only in ALUWB.
- op=0000011 with mem_ready low for 2 cycles in MEMREAD → 7 total cycles; result_src=01 and reg_write=1 in MEMWB.
- op=1100011, funct3=001, zero=0 → pc_write=1 in BRANCH; repeat with zero=1 → pc_write=0.
- op=0100011 with mem_ready delayed 3 cycles → mem_write held high for 4 cycles, adr_src=1, then FETCH.
- op=1111111 → ILLEGAL, illegal=1 held for 10 cycles with no enables; reset=0 clears it.
